// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and grant-source encodings for the register-file write arbiter.
// The optional bypass outputs are enabled with RF_WRITE_BYPASS_EN.
package rf_write_arbiter_pkg;
  localparam int RF_WIDTH  = 32;
  localparam int RF_NREGS  = 32;
  localparam int RF_ADDR_W = $clog2(RF_NREGS);

  typedef enum logic [1:0] {GNT_NONE, GNT_A, GNT_B} gnt_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writer-side bus: port A writeback (no back-pressure) and port B valid/ready request.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int ADDR  = RF_ADDR_W
);
  logic             wb_valid;
  logic [ADDR-1:0]  wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic             ll_valid;
  logic             ll_ready;
  logic [ADDR-1:0]  ll_reg;
  logic [WIDTH-1:0] ll_data;

  modport master (output wb_valid, wb_reg, wb_data, ll_valid, ll_reg, ll_data, input ll_ready);
  modport slave  (input wb_valid, wb_reg, wb_data, ll_valid, ll_reg, ll_data, output ll_ready);
endinterface

// File: rtl/rf_write_arbiter_wb_fifo.sv
// Synchronous FIFO holding long-latency writes ({reg, data}); head is the next entry to pop.
module rf_wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: port A wins, port B drains a FIFO, with starvation stall
// and pending-destination scoreboard. Define RF_WRITE_BYPASS_EN for operand bypass outputs.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int NREGS      = RF_NREGS,
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 4,
  localparam int ADDR      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  rf_write_arbiter_if.slave bus,
  input  logic             issue_valid,
  input  logic [ADDR-1:0]  issue_reg,
  input  logic [ADDR-1:0]  q_rs,
  input  logic [ADDR-1:0]  q_rt,
  input  logic [ADDR-1:0]  q_rd,
  output logic             hz_rs,
  output logic             hz_rt,
  output logic             hz_rd,
  output logic             stall_req,
  output logic             rf_regwrite,
  output logic [ADDR-1:0]  rf_wreg,
  output logic [WIDTH-1:0] rf_wdata
`ifdef RF_WRITE_BYPASS_EN
  ,
  output logic             byp_rs_hit,
  output logic             byp_rt_hit,
  output logic [WIDTH-1:0] byp_data
`endif
);
  localparam int EW = WIDTH + ADDR;
  localparam int CW = $clog2(STARVE_MAX) + 1;

  logic             push, pop, full, empty, b_write;
  logic [EW-1:0]    head;
  logic [ADDR-1:0]  head_reg;
  logic [WIDTH-1:0] head_data;
  logic [CW-1:0]    starve_cnt;
  logic [NREGS-1:0] busy, busy_nxt;
  gnt_e             gnt;

  // Ready comes from the registered count only, so a pop never opens a full FIFO same-cycle.
  assign bus.ll_ready = !full && !reset;
  assign push         = bus.ll_valid && bus.ll_ready;

  rf_wb_fifo #(.W(EW), .DEPTH(LL_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({bus.ll_reg, bus.ll_data}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign {head_reg, head_data} = head;

  // A write to $0 from port A is treated as no request, leaving the port to the FIFO.
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (bus.wb_valid && bus.wb_reg != '0) gnt = GNT_A;
      else if (!empty)                      gnt = GNT_B;
    end
  end

  assign pop         = (gnt == GNT_B);
  assign b_write     = pop && (head_reg != '0);
  assign rf_regwrite = (gnt == GNT_A) || b_write;
  assign rf_wreg     = (gnt == GNT_A) ? bus.wb_reg  : head_reg;
  assign rf_wdata    = (gnt == GNT_A) ? bus.wb_data : head_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      if (pop || empty)        starve_cnt <= '0;
      else if (starve_cnt != '1) starve_cnt <= starve_cnt + CW'(1);
      if (pop)                 stall_req <= 1'b0;
      else if (!empty && starve_cnt >= CW'(STARVE_MAX - 1)) stall_req <= 1'b1;
    end
  end

  // Issue is applied after the pop clear so a same-cycle set wins.
  always_comb begin
    busy_nxt = busy;
    if (b_write) busy_nxt[head_reg] = 1'b0;
    if (issue_valid && issue_reg != '0) busy_nxt[issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

`ifdef RF_WRITE_BYPASS_EN
  assign byp_rs_hit = b_write && (head_reg == q_rs) && (q_rs != '0);
  assign byp_rt_hit = b_write && (head_reg == q_rt) && (q_rt != '0);
  assign byp_data   = rf_wdata;
  assign hz_rs      = !reset && busy[q_rs] && !byp_rs_hit;
  assign hz_rt      = !reset && busy[q_rt] && !byp_rt_hit;
`else
  assign hz_rs      = !reset && busy[q_rs];
  assign hz_rt      = !reset && busy[q_rt];
`endif
  assign hz_rd      = !reset && busy[q_rd];
endmodule
